// File: rtl/foo_counter_ctrl_if.sv
// Bundle between the test-control logic, the run sequencer and the external counter.
// start is sampled on a single edge in IDLE; done is a one-cycle valid for result/aborted/err with no ready.
interface foo_counter_ctrl_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] len;
    logic         abort;
    logic [W-1:0] cnt_in;
    logic         cnt_en;
    logic         cnt_rst;
    logic         busy;
    logic         done;
    logic         aborted;
    logic         err;
    logic [W-1:0] result;
    logic [2:0]   state_dbg;

    modport master (
        output start, len, abort, cnt_in,
        input  cnt_en, cnt_rst, busy, done, aborted, err, result, state_dbg
    );

    modport slave (
        input  start, len, abort, cnt_in,
        output cnt_en, cnt_rst, busy, done, aborted, err, result, state_dbg
    );
endinterface

// File: rtl/foo_counter_ctrl.sv
// Run sequencer for an external W-bit up-counter: clear, enable for len cycles, settle,
// capture the count and compare it against an internal tally to detect counter faults.
module foo_counter_ctrl #(
    parameter int W = 8
) (
    input logic               clk,
    input logic               rst,
    foo_counter_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_RUN    = 3'd2,
        S_SETTLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t       state;
    logic [W-1:0] len_q;
    logic [W-1:0] tally;
    logic [W-1:0] tally_nxt;
    logic [W-1:0] result_q;
    logic         aborted_q;
    logic         err_q;

    assign tally_nxt = tally + W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            len_q     <= '0;
            tally     <= '0;
            result_q  <= '0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        len_q     <= bus.len;
                        tally     <= '0;
                        aborted_q <= 1'b0;
                        err_q     <= 1'b0;
                        state     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (bus.abort) begin
                        aborted_q <= 1'b1;
                        state     <= S_SETTLE;
                    end else if (len_q == '0) begin
                        state <= S_SETTLE;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // The enable is already high this cycle, so an abort still counts it.
                    tally <= tally_nxt;
                    if (bus.abort) begin
                        aborted_q <= 1'b1;
                        state     <= S_SETTLE;
                    end else if (tally_nxt == len_q) begin
                        state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    result_q <= bus.cnt_in;
                    err_q    <= (bus.cnt_in != tally);
                    state    <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Control outputs come straight from the state register, so no input reaches them combinationally.
    assign bus.cnt_en    = (state == S_RUN);
    assign bus.cnt_rst   = (state == S_CLEAR);
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.aborted   = aborted_q;
    assign bus.err       = err_q;
    assign bus.result    = result_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_foo_counter_ctrl.sv
// Bench for foo_counter_ctrl: a behavioural counter model, directed run tasks that push expected
// completions into a queue, and a negedge monitor that pops and compares on every done pulse.
module tb_foo_counter_ctrl;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic         ab;
        logic         er;
        logic [15:0]  en;
        logic [15:0]  bsy;
        logic [31:0]  dcyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;
    int   en_cnt = 0;
    int   rst_cnt = 0;
    int   busy_cnt = 0;
    exp_t exp_q[$];

    logic [W-1:0] cnt = '0;
    logic         skip_arm = 1'b0;
    logic         skip_used = 1'b0;

    foo_counter_ctrl_if #(.W(W)) bus ();

    foo_counter_ctrl #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and cycle count
    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Counter model: sync clear, +1 per enabled edge, optionally drops one increment
    assign bus.cnt_in = cnt;
    always @(posedge clk) begin
        if (bus.cnt_rst) begin
            cnt <= '0;
        end else if (bus.cnt_en) begin
            if (skip_arm && !skip_used) skip_used <= 1'b1;
            else                        cnt <= cnt + W'(1);
        end
        if (!skip_arm) skip_used <= 1'b0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            en_cnt   = 0;
            rst_cnt  = 0;
            busy_cnt = 0;
        end else begin
            if (bus.cnt_en === 1'b1)  en_cnt++;
            if (bus.cnt_rst === 1'b1) rst_cnt++;
            if (bus.busy === 1'b1)    busy_cnt++;
            if (bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result", bus.result, e.res);
                    chk("aborted", bus.aborted, e.ab);
                    chk("err", bus.err, e.er);
                    chk("en_cycles", en_cnt, e.en);
                    chk("rst_pulses", rst_cnt, 1);
                    chk("busy_cycles", busy_cnt, e.bsy);
                    chk("done_cycle", cyc, e.dcyc);
                end
                done_seen++;
                en_cnt   = 0;
                rst_cnt  = 0;
                busy_cnt = 0;
            end
        end
    end

    task automatic wait_done();
        int d0;
        int n;
        d0 = done_seen;
        n  = 0;
        while (done_seen == d0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("done_timeout", done_seen - d0, 1);
    endtask

    // ab_at > 0: abort during that RUN cycle; ab_at < 0: abort together with start
    task automatic run_one(input logic [W-1:0] l, input int ab_at, input bit extra, input bit skip,
                           input logic [W-1:0] e_res, input bit e_ab, input bit e_er, input int e_en);
        exp_t e;
        int   ck;
        skip_arm  = skip;
        bus.len   = l;
        bus.start = 1'b1;
        if (ab_at < 0) bus.abort = 1'b1;
        @(posedge clk);
        #1;
        ck        = cyc;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        e.res  = e_res;
        e.ab   = e_ab;
        e.er   = e_er;
        e.en   = 16'(e_en);
        e.bsy  = 16'(e_en + 3);
        e.dcyc = 32'(ck + e_en + 2);
        exp_q.push_back(e);
        if (ab_at > 0) begin
            repeat (ab_at) @(posedge clk);
            #1 bus.abort = 1'b1;
            @(posedge clk);
            #1 bus.abort = 1'b0;
        end
        if (extra) begin
            repeat (2) begin
                @(posedge clk);
                #1 bus.start = 1'b1;
                @(posedge clk);
                #1 bus.start = 1'b0;
            end
        end
        wait_done();
        skip_arm = 1'b0;
    endtask

    task automatic reset_mid_run();
        bus.len   = 8'd20;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_cnt_en", bus.cnt_en, 0);
        chk("rst_mid_cnt_rst", bus.cnt_rst, 0);
        chk("rst_mid_done", bus.done, 0);
        chk("rst_mid_result", bus.result, 0);
        chk("rst_mid_aborted", bus.aborted, 0);
        chk("rst_mid_state", bus.state_dbg, 0);
        repeat (30) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.len   = '0;
        bus.abort = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_busy", bus.busy, 0);
            chk("idle_cnt_en", bus.cnt_en, 0);
            chk("idle_cnt_rst", bus.cnt_rst, 0);
            chk("idle_done", bus.done, 0);
        end
        chk("idle_result", bus.result, 0);
        chk("idle_aborted", bus.aborted, 0);
        chk("idle_err", bus.err, 0);
        @(posedge clk);
        #1;

        run_one(8'd5,   0, 1'b0, 1'b0, 8'd5,   1'b0, 1'b0, 5);
        run_one(8'd10,  4, 1'b0, 1'b0, 8'd4,   1'b1, 1'b0, 4);
        run_one(8'd0,   0, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 0);
        run_one(8'd255, 0, 1'b0, 1'b0, 8'd255, 1'b0, 1'b0, 255);
        run_one(8'd1,   0, 1'b0, 1'b0, 8'd1,   1'b0, 1'b0, 1);
        run_one(8'd8,   0, 1'b1, 1'b1, 8'd7,   1'b0, 1'b1, 8);
        run_one(8'd2,  -1, 1'b0, 1'b0, 8'd2,   1'b0, 1'b0, 2);
        reset_mid_run();
        run_one(8'd3,   0, 1'b0, 1'b0, 8'd3,   1'b0, 1'b0, 3);

        repeat (3) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
